button_debounce_bank: RTL and testbench
=======================================

Name: button_debounce_bank

Overview:
- Parametrised successor to the single-button debouncer: CHANNELS independent push-button inputs, each with a two-flop synchroniser and a symmetric debouncer that filters both press and release bounce.
- Each channel exports a clean level, single-cycle press and release pulses, and an optional hold/auto-repeat pulse.
- Sits between the board push-buttons and the FP adder test-harness control logic (operand select, step, display mode), replacing per-button debouncer instances.

Parameters:
- CHANNELS, 5, number of independent button channels (>=1).
- LIMIT, 100000, consecutive stable synchronised samples required to accept a level change (>=2; bench uses 4).
- ACTIVE_HIGH, 1, 1: raw pressed = 1; 0: raw pressed = 0 (inverted after synchronisation).
- HOLD_LIMIT, 50000000, cycles of continuous debounced press before the first repeat pulse; 0 disables hold/repeat.
- REPEAT_LIMIT, 10000000, cycles between subsequent repeat pulses while still held (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- button  in  CHANNELS  raw asynchronous button inputs.
- level  out  CHANNELS  debounced pressed state, 1 = pressed.
- press  out  CHANNELS  one-cycle pulse on accepted 0->1 of level.
- release  out  CHANNELS  one-cycle pulse on accepted 1->0 of level.
- repeat_pulse  out  CHANNELS  one-cycle hold/auto-repeat pulse.
- any_press  out  1  registered OR of the press vector from the same cycle (one cycle after press).

Behaviour:
- Reset (reset = 0, asynchronous): sync flops, counters, level, press, release, repeat_pulse and any_press all cleared to 0. Release is synchronous to clk via the normal flop path.
- Synchroniser: two flops per channel. Polarity normalised after the second flop: norm = sync2 XOR !ACTIVE_HIGH.
- Debounce counter: width clog2(LIMIT), local.
  - norm == level: counter <= 0.
  - norm != level and counter == LIMIT-1: level <= norm, counter <= 0.
  - norm != level otherwise: counter <= counter + 1.
- Latency: a raw change held steady is first sampled at edge E; level updates at edge E+LIMIT+1.
- Glitch rejection: any sample equal to level before the count completes restarts the count. A pulse narrower than LIMIT synchronised cycles never changes level.
- press / release: registered, asserted in the cycle following the edge where level changes, for exactly one cycle. Never both asserted together on one channel.
- Hold/repeat (HOLD_LIMIT > 0): per-channel hold counter.
  - Cleared while level == 0 and on the edge level rises.
  - Counts while level == 1.
  - First repeat_pulse after HOLD_LIMIT cycles of level high, then one every REPEAT_LIMIT cycles while level stays 1.
  - Release clears the counter immediately; no repeat_pulse in the cycle release is asserted.
  - Hold counter saturates in the repeat phase; no wrap-around.
- HOLD_LIMIT = 0: repeat_pulse tied to 0, hold counters not instantiated.
- Channels fully independent; simultaneous events on several channels produce simultaneous pulses.
- Button held pressed through reset release: treated as a new press; press asserted LIMIT+2 edges after reset deassertion.
- Reset mid-count: count discarded, no pulse emitted.

Decomposition:
- Shared package/header holds: default LIMIT/HOLD_LIMIT/REPEAT_LIMIT values for the 100 MHz board clock, plus simulation overrides (LIMIT=4, HOLD_LIMIT=10, REPEAT_LIMIT=5).
- One sub-module, debounce_channel: synchroniser, debounce counter, edge pulses and hold logic for one bit.
- Top level contains only a generate loop over CHANNELS and the any_press OR register.

Test Plan (CHANNELS=2, LIMIT=4, HOLD_LIMIT=10, REPEAT_LIMIT=5, ACTIVE_HIGH=1):
- Clean press: button[0] 0->1 sampled at edge E, held -> level[0]=1 at E+5; press[0]=1 for exactly one cycle after E+5; any_press=1 one cycle later; channel 1 stays 0.
- Bounce: button[0] toggles 1,0,1,0 on single cycles, then holds 1 -> no intermediate level change; exactly one press pulse, 5 edges after the final rising sample.
- Release with bounce: after stable press, button[0] drops with a 2-cycle 1-glitch, then holds 0 -> exactly one release pulse; level[0]=0; repeat_pulse never fires during release.
- Hold/repeat: hold button[1]=1 for 40 cycles after level rises -> repeat_pulse[1] at +10, +15, +20, +25, +30, +35 cycles; release stops pulses immediately.
- Reset: assert reset low mid-count (counter=2) with button[0]=1 -> all outputs 0 asynchronously; after release with button still 1 -> press[0] LIMIT+2 = 6 edges after deassertion.
- Polarity: rebuild with ACTIVE_HIGH=0, drive button[0]=1 idle then 0 -> level[0]=1 and press[0] with identical timing to the clean-press case.

Source files
------------

// File: rtl/button_debounce_bank_pkg.sv
// Shared constants and sizing helpers for the push-button debounce bank.
package button_debounce_bank_pkg;

  // Board defaults for the 100 MHz clock: 1 ms debounce, 0.5 s hold, 0.1 s repeat.
  localparam int unsigned DEF_LIMIT        = 100_000;
  localparam int unsigned DEF_HOLD_LIMIT   = 50_000_000;
  localparam int unsigned DEF_REPEAT_LIMIT = 10_000_000;

  // Short values so simulation reaches every behaviour in a few hundred cycles.
  localparam int unsigned SIM_LIMIT        = 4;
  localparam int unsigned SIM_HOLD_LIMIT   = 10;
  localparam int unsigned SIM_REPEAT_LIMIT = 5;

  // Bits needed for a counter that runs 0 .. max_count-1 (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    if (max_count < 2) return 1;
    return $clog2(max_count);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_bank_channel.sv
// One button channel: 2-flop synchroniser, symmetric debouncer, edge pulses, hold/repeat.
module debounce_channel
  import button_debounce_bank_pkg::*;
#(
  parameter int unsigned LIMIT        = DEF_LIMIT,
  parameter bit          ACTIVE_HIGH  = 1'b1,
  parameter int unsigned HOLD_LIMIT   = DEF_HOLD_LIMIT,
  parameter int unsigned REPEAT_LIMIT = DEF_REPEAT_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CW = cnt_width(LIMIT);

  logic          sync1;
  logic          sync2;
  logic          norm_c;
  logic          accept_c;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Polarity is folded in after synchronisation so norm is always 1 = pressed.
  assign norm_c   = sync2 ^ !ACTIVE_HIGH;
  assign accept_c = (norm_c != level) && (cnt == CW'(LIMIT - 1));

  // Debounce counter: any sample agreeing with level restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (norm_c == level) begin
      cnt <= '0;
    end else if (accept_c) begin
      cnt   <= '0;
      level <= norm_c;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Press/release pulses issued on the same edge that level changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= accept_c & norm_c;
      release_pulse <= accept_c & ~norm_c;
    end
  end

  if (HOLD_LIMIT > 0) begin : g_hold
    localparam int unsigned HW = cnt_width(max_u(HOLD_LIMIT, REPEAT_LIMIT));

    logic [HW-1:0] hold_cnt;
    logic          rep_phase;
    logic          fall_c;

    // Level is about to drop this edge: suppress any repeat and clear at once.
    assign fall_c = accept_c & level;

    // Hold/repeat timer: first pulse after HOLD_LIMIT, then every REPEAT_LIMIT.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_cnt     <= '0;
        rep_phase    <= 1'b0;
        repeat_pulse <= 1'b0;
      end else if (!level || fall_c) begin
        hold_cnt     <= '0;
        rep_phase    <= 1'b0;
        repeat_pulse <= 1'b0;
      end else if (!rep_phase && (hold_cnt == HW'(HOLD_LIMIT - 1))) begin
        hold_cnt     <= '0;
        rep_phase    <= 1'b1;
        repeat_pulse <= 1'b1;
      end else if (rep_phase && (hold_cnt == HW'(REPEAT_LIMIT - 1))) begin
        hold_cnt     <= '0;
        repeat_pulse <= 1'b1;
      end else begin
        hold_cnt     <= hold_cnt + HW'(1);
        repeat_pulse <= 1'b0;
      end
    end
  end else begin : g_no_hold
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent debounced push-button channels with a combined press flag.
module button_debounce_bank
  import button_debounce_bank_pkg::*;
#(
  parameter int unsigned CHANNELS     = 5,
  parameter int unsigned LIMIT        = DEF_LIMIT,
  parameter bit          ACTIVE_HIGH  = 1'b1,
  parameter int unsigned HOLD_LIMIT   = DEF_HOLD_LIMIT,
  parameter int unsigned REPEAT_LIMIT = DEF_REPEAT_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_press
);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
    debounce_channel #(
      .LIMIT        (LIMIT),
      .ACTIVE_HIGH  (ACTIVE_HIGH),
      .HOLD_LIMIT   (HOLD_LIMIT),
      .REPEAT_LIMIT (REPEAT_LIMIT)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .button        (button[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  // One-cycle-delayed OR of all press pulses for the harness control logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press;
    end
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Randomised scoreboard bench: active-high and active-low banks vs a reference model.
module tb_button_debounce_bank;
  import button_debounce_bank_pkg::*;

  localparam int unsigned CH = 2;
  localparam int unsigned LIM = SIM_LIMIT;
  localparam int unsigned HL = SIM_HOLD_LIMIT;
  localparam int unsigned RL = SIM_REPEAT_LIMIT;

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] rep;
    logic          anyp;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] btn;
  logic [CH-1:0] btn_n;
  logic [CH-1:0] level0, press0, rel0, rep0;
  logic [CH-1:0] level1, press1, rel1, rep1;
  logic          any0, any1;

  assign btn_n = ~btn;

  button_debounce_bank #(
    .CHANNELS(CH), .LIMIT(LIM), .ACTIVE_HIGH(1'b1), .HOLD_LIMIT(HL), .REPEAT_LIMIT(RL)
  ) dut_ah (
    .clk(clk), .reset(reset), .button(btn), .level(level0), .press(press0),
    .release_pulse(rel0), .repeat_pulse(rep0), .any_press(any0)
  );

  button_debounce_bank #(
    .CHANNELS(CH), .LIMIT(LIM), .ACTIVE_HIGH(1'b0), .HOLD_LIMIT(HL), .REPEAT_LIMIT(RL)
  ) dut_al (
    .clk(clk), .reset(reset), .button(btn_n), .level(level1), .press(press1),
    .release_pulse(rel1), .repeat_pulse(rep1), .any_press(any1)
  );

  always #5 clk = ~clk;

  obs_t exp_q0[$];
  obs_t exp_q1[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, index [dut][channel]; dut 1 sees inverted raw buttons.
  logic        m_h1  [2][CH];
  logic        m_h2  [2][CH];
  logic        m_lvl [2][CH];
  int unsigned m_run [2][CH];
  longint      m_rise[2][CH];
  logic        m_prev_any[2];
  longint      cyc = 0;

  // Model: level flips once LIM consecutive synchronised samples disagree with it;
  // repeats fall at HL, HL+RL, HL+2RL ... cycles after the rise while still pressed.
  always @(posedge clk) begin
    obs_t e;
    for (int d = 0; d < 2; d++) begin
      e = '0;
      if (!reset) begin
        for (int c = 0; c < int'(CH); c++) begin
          m_h1[d][c]  = 1'b0;
          m_h2[d][c]  = 1'b0;
          m_lvl[d][c] = 1'b0;
          m_run[d][c] = 0;
        end
        m_prev_any[d] = 1'b0;
      end else begin
        for (int c = 0; c < int'(CH); c++) begin
          logic   seen;
          logic   raw;
          longint held;
          seen = (d == 1) ? !m_h2[d][c] : m_h2[d][c];
          raw  = (d == 1) ? btn_n[c] : btn[c];
          if (seen != m_lvl[d][c]) m_run[d][c] = m_run[d][c] + 1;
          else                     m_run[d][c] = 0;
          if (m_run[d][c] == LIM) begin
            m_lvl[d][c] = seen;
            m_run[d][c] = 0;
            e.press[c]  = seen;
            e.rel[c]    = !seen;
            if (seen) m_rise[d][c] = cyc;
          end
          if (m_lvl[d][c]) begin
            held = cyc - m_rise[d][c];
            e.rep[c] = (held >= longint'(HL)) && (((held - longint'(HL)) % longint'(RL)) == 0);
          end
          e.level[c] = m_lvl[d][c];
          m_h2[d][c] = m_h1[d][c];
          m_h1[d][c] = raw;
        end
        e.anyp        = m_prev_any[d];
        m_prev_any[d] = |e.press;
      end
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    cyc++;
  end

  task automatic score(input int d, input obs_t act);
    obs_t e;
    checks++;
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL sb_dut%0d t=%0t actual=output present required=queued expectation", d, $time);
    end else begin
      e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL sb_dut%0d t=%0t actual lvl=%b prs=%b rel=%b rep=%b any=%b required lvl=%b prs=%b rel=%b rep=%b any=%b",
                 d, $time, act.level, act.press, act.rel, act.rep, act.anyp,
                 e.level, e.press, e.rel, e.rep, e.anyp);
      end
    end
  endtask

  // Monitor: every cycle the banks present outputs, pop and compare.
  initial begin
    obs_t a0;
    obs_t a1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      a0 = '{level: level0, press: press0, rel: rel0, rep: rep0, anyp: any0};
      a1 = '{level: level1, press: press1, rel: rel1, rep: rep1, anyp: any1};
      score(0, a0);
      score(1, a1);
    end
  end

  task automatic drive(input logic [CH-1:0] b, input int unsigned n);
    @(negedge clk);
    btn = b;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_async_zero(input string name);
    logic [4*CH:0] v0;
    logic [4*CH:0] v1;
    v0 = {level0, press0, rel0, rep0, any0};
    v1 = {level1, press1, rel1, rep1, any1};
    checks++;
    if (v0 !== '0 || v1 !== '0) begin
      errors++;
      $display("FAIL %s actual ah=%b al=%b required all zero", name, v0, v1);
    end
  endtask

  task automatic check_level(input string name, input logic [CH-1:0] req);
    checks++;
    if (level0 !== req || level1 !== req) begin
      errors++;
      $display("FAIL %s actual ah=%b al=%b required=%b", name, level0, level1, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    btn   = '0;
    repeat (3) @(negedge clk);
    #1 check_async_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 6);
    // Clean press on channel 0, held long enough to see repeats.
    drive(2'b01, 14);
    check_level("clean_press_level", 2'b01);
    // Release with a two-cycle high glitch.
    drive(2'b00, 1);
    drive(2'b01, 2);
    drive(2'b00, 12);
    check_level("release_level", 2'b00);
    // Single-cycle bounce before a steady press, then release.
    drive(2'b01, 1);
    drive(2'b00, 1);
    drive(2'b01, 1);
    drive(2'b00, 1);
    drive(2'b01, 10);
    drive(2'b00, 10);
    // Long hold on channel 1 for the auto-repeat train.
    drive(2'b10, 50);
    drive(2'b00, 15);
    // Reset mid-count on channel 0 while channel 1 is pressed.
    drive(2'b10, 10);
    check_level("pre_reset_level", 2'b10);
    drive(2'b11, 4);
    #1 reset = 1'b0;
    #1 check_async_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(2'b11, 14);
    check_level("press_through_reset", 2'b11);
    drive(2'b00, 12);
    // Random segments exercising bounce, glitches and simultaneous events.
    for (int i = 0; i < 70; i++) begin
      drive(CH'($urandom), $urandom_range(1, 18));
    end
    drive(2'b11, 30);
    drive(2'b00, 12);
    check_level("final_level", 2'b00);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
